// File: rtl/tri_mem_loader_if.sv
// Triangle loader bus definitions.
//   tri_mem_loader_pkg : triangle payload types (default TRI_BITS comes from triangle_t).
//   tri_mem_loader_if  : host byte stream (in_byte/in_valid/in_ready) plus the
//                        triangle RAM write port (wr_en/wr_bank/wr_addr/wr_data).
//   modport master     : the loader side (consumes the stream, drives the RAM write).
//   modport slave      : the environment side (drives the stream, observes the RAM write).

package tri_mem_loader_pkg;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } vertex_t;

    typedef struct packed {
        vertex_t     v0;
        vertex_t     v1;
        vertex_t     v2;
        logic [15:0] color;
    } triangle_t;

endpackage

interface tri_mem_loader_if #(
    parameter int unsigned N_TRIS_MAX = 256,
    parameter int unsigned TRI_BITS   = $bits(tri_mem_loader_pkg::triangle_t)
);
    localparam int unsigned ADDR_W = (N_TRIS_MAX > 1) ? $clog2(N_TRIS_MAX) : 1;

    logic [7:0]          in_byte;
    logic                in_valid;
    logic                in_ready;

    logic                wr_en;
    logic                wr_bank;
    logic [ADDR_W-1:0]   wr_addr;
    logic [TRI_BITS-1:0] wr_data;

    modport master (
        input  in_byte, in_valid,
        output in_ready, wr_en, wr_bank, wr_addr, wr_data
    );

    modport slave (
        output in_byte, in_valid,
        input  in_ready, wr_en, wr_bank, wr_addr, wr_data
    );

endinterface

// File: rtl/tri_mem_loader.sv
// tri_mem_loader: assembles triangle packets from a host byte stream into the
// back bank of a two-bank triangle RAM and commits the scene at the next frame
// boundary, so the feeder never reads a half-loaded bank.
//
// Packet: 0xA5, N[15:8], N[7:0], N*TRI_BYTES payload bytes (MSB byte first),
// then an XOR checksum byte when TRI_LOADER_CSUM_EN is defined.
//
// Ports:
//   clk_render, rst_render : clock, asynchronous active-high reset
//   bus (master)           : in_byte/in_valid/in_ready stream, wr_* RAM write port
//   frame_start_i          : one-cycle frame-boundary pulse
//   rd_bank_o              : bank the feeder reads (wr_bank is always its inverse)
//   tri_count_o            : committed triangle count
//   load_done_o            : one-cycle pulse when a scene is committed
//   load_error_o           : one-cycle pulse when a packet is rejected
//   busy_o                 : high whenever the loader is not idle
//
// Build option: define TRI_LOADER_CSUM_EN to require and verify the trailing
// checksum byte.

module tri_mem_loader
    import tri_mem_loader_pkg::*;
#(
    parameter int unsigned N_TRIS_MAX = 256,
    parameter int unsigned TRI_BITS   = $bits(triangle_t),
    parameter int unsigned INIT_COUNT = 0
) (
    input  logic                              clk_render,
    input  logic                              rst_render,
    tri_mem_loader_if.master                  bus,
    input  logic                              frame_start_i,
    output logic                              rd_bank_o,
    output logic [$clog2(N_TRIS_MAX+1)-1:0]   tri_count_o,
    output logic                              load_done_o,
    output logic                              load_error_o,
    output logic                              busy_o
);

    localparam int unsigned TRI_BYTES = (TRI_BITS + 7) / 8;
    localparam int unsigned PRE_W     = (TRI_BYTES > 1) ? (TRI_BYTES - 1) * 8 : 8;
    localparam int unsigned BYTE_W    = (TRI_BYTES > 1) ? $clog2(TRI_BYTES) : 1;
    localparam int unsigned ADDR_W    = (N_TRIS_MAX > 1) ? $clog2(N_TRIS_MAX) : 1;
    localparam int unsigned CNT_W     = $clog2(N_TRIS_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_HI,
        S_CNT_LO,
        S_PAYLOAD,
        S_CSUM,
        S_PENDING
    } state_e;

    state_e                state_q,     state_d;
    logic [7:0]            cnt_hi_q,    cnt_hi_d;
    logic [CNT_W-1:0]      count_q,     count_d;
    logic [BYTE_W-1:0]     byte_idx_q,  byte_idx_d;
    logic [CNT_W-1:0]      tri_idx_q,   tri_idx_d;
    logic [PRE_W-1:0]      asm_q,       asm_d;
`ifdef TRI_LOADER_CSUM_EN
    logic [7:0]            csum_q,      csum_d;
`endif

    logic                  in_ready_q,   in_ready_d;
    logic                  busy_q,       busy_d;
    logic                  wr_en_q,      wr_en_d;
    logic                  wr_bank_q,    wr_bank_d;
    logic [ADDR_W-1:0]     wr_addr_q,    wr_addr_d;
    logic [TRI_BITS-1:0]   wr_data_q,    wr_data_d;
    logic                  rd_bank_q,    rd_bank_d;
    logic [CNT_W-1:0]      tri_count_q,  tri_count_d;
    logic                  load_done_q,  load_done_d;
    logic                  load_error_q, load_error_d;

    logic                  accept_c;
    logic [15:0]           n_full_c;
    logic                  n_bad_c;
    logic                  byte_last_c;
    logic                  tri_last_c;
    logic [PRE_W+7:0]      asm_full_c;

    // Handshake and packet-field decode.
    assign accept_c    = bus.in_valid && in_ready_q;
    assign n_full_c    = {cnt_hi_q, bus.in_byte};
    assign n_bad_c     = (n_full_c == 16'd0) || (n_full_c > 16'(N_TRIS_MAX));
    assign byte_last_c = (byte_idx_q == BYTE_W'(TRI_BYTES - 1));
    assign tri_last_c  = (tri_idx_q == (count_q - CNT_W'(1)));
    // Earlier bytes of the triangle sit above the byte being accepted.
    assign asm_full_c  = {asm_q, bus.in_byte};

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_hi_d     = cnt_hi_q;
        count_d      = count_q;
        byte_idx_d   = byte_idx_q;
        tri_idx_d    = tri_idx_q;
        asm_d        = asm_q;
`ifdef TRI_LOADER_CSUM_EN
        csum_d       = csum_q;
`endif
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        rd_bank_d    = rd_bank_q;
        wr_bank_d    = wr_bank_q;
        tri_count_d  = tri_count_q;
        load_done_d  = 1'b0;
        load_error_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept_c && (bus.in_byte == 8'hA5)) begin
                    state_d = S_CNT_HI;
                end
            end

            S_CNT_HI: begin
                if (accept_c) begin
                    cnt_hi_d = bus.in_byte;
                    state_d  = S_CNT_LO;
                end
            end

            S_CNT_LO: begin
                if (accept_c) begin
                    if (n_bad_c) begin
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        count_d    = CNT_W'(n_full_c);
                        byte_idx_d = '0;
                        tri_idx_d  = '0;
                        wr_addr_d  = '0;
`ifdef TRI_LOADER_CSUM_EN
                        csum_d     = 8'h00;
`endif
                        state_d    = S_PAYLOAD;
                    end
                end
            end

            S_PAYLOAD: begin
                if (accept_c) begin
`ifdef TRI_LOADER_CSUM_EN
                    csum_d = csum_q ^ bus.in_byte;
`endif
                    asm_d = PRE_W'(asm_full_c);
                    if (byte_last_c) begin
                        byte_idx_d = '0;
                        wr_en_d    = 1'b1;
                        wr_addr_d  = ADDR_W'(tri_idx_q);
                        wr_data_d  = asm_full_c[TRI_BITS-1:0];
                        tri_idx_d  = tri_idx_q + CNT_W'(1);
                        if (tri_last_c) begin
`ifdef TRI_LOADER_CSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_PENDING;
`endif
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BYTE_W'(1);
                    end
                end
            end

            S_CSUM: begin
`ifdef TRI_LOADER_CSUM_EN
                if (accept_c) begin
                    if (bus.in_byte == csum_q) begin
                        state_d = S_PENDING;
                    end else begin
                        load_error_d = 1'b1;
                        state_d      = S_IDLE;
                    end
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_PENDING: begin
                // Only a frame_start seen while already pending commits the scene.
                if (frame_start_i) begin
                    rd_bank_d   = ~rd_bank_q;
                    wr_bank_d   = rd_bank_q;
                    tri_count_d = count_q;
                    load_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered from the next state so they line up with state_q.
        in_ready_d = (state_d != S_PENDING);
        busy_d     = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            state_q      <= S_IDLE;
            cnt_hi_q     <= 8'h00;
            count_q      <= '0;
            byte_idx_q   <= '0;
            tri_idx_q    <= '0;
            asm_q        <= '0;
`ifdef TRI_LOADER_CSUM_EN
            csum_q       <= 8'h00;
`endif
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_bank_q    <= 1'b1;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_bank_q    <= 1'b0;
            tri_count_q  <= CNT_W'(INIT_COUNT);
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            count_q      <= count_d;
            byte_idx_q   <= byte_idx_d;
            tri_idx_q    <= tri_idx_d;
            asm_q        <= asm_d;
`ifdef TRI_LOADER_CSUM_EN
            csum_q       <= csum_d;
`endif
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            wr_en_q      <= wr_en_d;
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_bank_q    <= rd_bank_d;
            tri_count_q  <= tri_count_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    assign rd_bank_o    = rd_bank_q;
    assign tri_count_o  = tri_count_q;
    assign load_done_o  = load_done_q;
    assign load_error_o = load_error_q;
    assign busy_o       = busy_q;

endmodule
